exec_encoder: RTL and testbench

EXEC_ENCODER -- requirements
Module: exec_encoder

---
 rtl/exec_encoder.sv | 153 +++++++++++++++
 tb/tb_exec_encoder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/exec_encoder.sv
// exec_encoder: turns scalar, vector and special instructions into a registered beat stream.
// Optional build macro EXEC_ENCODER_ILLEGAL_DROP_EN: func=0/opcode=111 is accepted and dropped.
`default_nettype none

module exec_encoder #(
  parameter int MAX_LEN = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_func,
  input  logic [2:0] in_opcode,
  input  logic [3:0] in_len,
  output logic [4:0] exec,
  output logic       exec_valid,
  input  logic       exec_ready,
  output logic [3:0] elem_idx,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCALAR = 2'd1,
    VECTOR = 2'd2
  } state_t;

  localparam logic [4:0] MAX_N = 5'(MAX_LEN);

  state_t     state, state_n;
  logic [4:0] exec_q, exec_n;
  logic       valid_q, valid_n;
  logic [3:0] idx_q, idx_n;
  logic [3:0] last_q, last_n;

  logic       xfer, xfer_last, accept;
  logic [4:0] len_n, beats;
  logic [3:0] ld_last;
  logic       is_vec, is_drop;
  state_t     ld_state;
  logic [4:0] ld_exec;
  logic       ld_valid;
  logic [3:0] idx_inc;

  assign xfer      = valid_q & exec_ready;
  assign xfer_last = xfer & exec_q[0];
  assign in_ready  = rst & ((state == IDLE) | xfer_last);
  assign accept    = in_valid & in_ready;
  assign idx_inc   = idx_q + 4'd1;

  // Decode of the offered instruction into what the encoder loads on acceptance.
  always_comb begin
    len_n = {1'b0, in_len};
    if ((in_len == 4'd0) || (len_n > MAX_N)) begin
      beats = MAX_N;
    end else begin
      beats = len_n;
    end
    ld_last = 4'(beats - 5'd1);

    is_vec = !in_func && ((in_opcode == 3'b001) || (in_opcode == 3'b100) ||
                          (in_opcode == 3'b101) || (in_opcode == 3'b110));
`ifdef EXEC_ENCODER_ILLEGAL_DROP_EN
    is_drop = !in_func && (in_opcode == 3'b111);
`else
    is_drop = 1'b0;
`endif

    ld_state = SCALAR;
    ld_exec  = {1'b0, in_opcode, 1'b1};
    ld_valid = 1'b1;
    if (is_drop) begin
      ld_state = IDLE;
      ld_exec  = 5'b00000;
      ld_valid = 1'b0;
    end else if (in_func) begin
      ld_exec = 5'b11111;
    end else if (is_vec) begin
      ld_state = VECTOR;
      ld_exec  = {1'b0, in_opcode, (ld_last == 4'd0)};
    end
  end

  always_comb begin
    state_n = state;
    exec_n  = exec_q;
    valid_n = valid_q;
    idx_n   = idx_q;
    last_n  = last_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = ld_state;
          exec_n  = ld_exec;
          valid_n = ld_valid;
          idx_n   = 4'd0;
          last_n  = ld_last;
        end
      end
      SCALAR, VECTOR: begin
        if (xfer_last) begin
          if (accept) begin
            state_n = ld_state;
            exec_n  = ld_exec;
            valid_n = ld_valid;
            idx_n   = 4'd0;
            last_n  = ld_last;
          end else begin
            state_n = IDLE;
            exec_n  = 5'b00000;
            valid_n = 1'b0;
            idx_n   = 4'd0;
            last_n  = 4'd0;
          end
        end else if (xfer) begin
          idx_n     = idx_inc;
          exec_n[0] = (idx_inc == last_q);
        end
      end
      default: begin
        state_n = IDLE;
        exec_n  = 5'b00000;
        valid_n = 1'b0;
        idx_n   = 4'd0;
        last_n  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      exec_q  <= 5'b00000;
      valid_q <= 1'b0;
      idx_q   <= 4'd0;
      last_q  <= 4'd0;
    end else begin
      state   <= state_n;
      exec_q  <= exec_n;
      valid_q <= valid_n;
      idx_q   <= idx_n;
      last_q  <= last_n;
    end
  end

  assign exec       = exec_q;
  assign exec_valid = valid_q;
  assign elem_idx   = idx_q;
  assign busy       = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_exec_encoder.sv
// Self-checking bench for exec_encoder: beat-queue model plus directed literal scenarios.
`default_nettype none

module tb_exec_encoder;

  localparam int MAX_LEN = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_func = 1'b0;
  logic [2:0] in_opcode = 3'd0;
  logic [3:0] in_len = 4'd0;
  logic [4:0] exec;
  logic       exec_valid;
  logic       exec_ready = 1'b1;
  logic [3:0] elem_idx;
  logic       busy;

  exec_encoder #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_func(in_func), .in_opcode(in_opcode), .in_len(in_len),
    .exec(exec), .exec_valid(exec_valid), .exec_ready(exec_ready),
    .elem_idx(elem_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit started = 0;

  // Model: the outstanding beats, head = beat currently on exec.
  logic [4:0] q_e[$];
  logic [3:0] q_i[$];
  // Log of beats the DUT actually transferred.
  int log_e[$];
  int log_i[$];
  int log_c[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_instr(input logic f, input logic [2:0] op, input logic [3:0] len);
    int n;
    if (f) begin
      q_e.push_back(5'b11111); q_i.push_back(4'd0);
    end else if (op == 3'b000 || op == 3'b010 || op == 3'b011) begin
      q_e.push_back({1'b0, op, 1'b1}); q_i.push_back(4'd0);
    end else if (op == 3'b111) begin
`ifndef EXEC_ENCODER_ILLEGAL_DROP_EN
      q_e.push_back(5'b01111); q_i.push_back(4'd0);
`endif
    end else begin
      n = (len == 0) ? MAX_LEN : ((int'(len) > MAX_LEN) ? MAX_LEN : int'(len));
      for (int i = 0; i < n; i++) begin
        q_e.push_back({1'b0, op, (i == n - 1)});
        q_i.push_back(4'(i));
      end
    end
  endtask

  always @(posedge clk) begin
    bit exp_rdy;
    cyc++;
    started = 1;
    if (rst && exec_valid && exec_ready) begin
      log_e.push_back(int'(exec));
      log_i.push_back(int'(elem_idx));
      log_c.push_back(cyc);
    end
    if (!rst) begin
      q_e.delete(); q_i.delete();
    end else begin
      exp_rdy = (q_e.size() == 0) || (q_e.size() == 1 && exec_ready);
      if (q_e.size() > 0 && exec_ready) begin
        void'(q_e.pop_front()); void'(q_i.pop_front());
      end
      if (in_valid && exp_rdy) push_instr(in_func, in_opcode, in_len);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("exec_valid", int'(exec_valid), int'(q_e.size() > 0));
      chk("exec", int'(exec), (q_e.size() > 0) ? int'(q_e[0]) : 0);
      chk("busy", int'(busy), int'(q_e.size() > 0));
      chk("in_ready", int'(in_ready),
          int'(rst && ((q_e.size() == 0) || (q_e.size() == 1 && exec_ready))));
      if (q_e.size() > 0) chk("elem_idx", int'(elem_idx), int'(q_i[0]));
    end
  end

  // Called aligned to posedge+1; returns aligned to posedge+1 after the accepting edge.
  task automatic send(input logic f, input logic [2:0] op, input logic [3:0] len,
                      output int acc_cyc);
    bit ok = 0, done = 0;
    in_valid = 1'b1; in_func = f; in_opcode = op; in_len = len;
    acc_cyc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
      if (ok) begin done = 1; acc_cyc = cyc; break; end
    end
    if (!done) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy && !exec_valid) begin done = 1; break; end
    end
    chk("idle_timeout", int'(done), 1);
    @(posedge clk); #1;
  endtask

  task automatic clear_log();
    log_e.delete(); log_i.delete(); log_c.delete();
  endtask

  task automatic chk_beat(input string nm, input int k, input int e, input int idx);
    chk({nm, "_exec"}, (k < log_e.size()) ? log_e[k] : -1, e);
    chk({nm, "_idx"},  (k < log_i.size()) ? log_i[k] : -1, idx);
  endtask

  initial begin
    int a, b, nlast;
    bit seen;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_exec_valid", int'(exec_valid), 0);
    chk("rst_exec", int'(exec), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_elem_idx", int'(elem_idx), 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    // Scalar op=010
    clear_log();
    send(1'b0, 3'b010, 4'd0, a);
    wait_idle();
    chk("scalar_count", log_e.size(), 1);
    chk_beat("scalar", 0, 5'b00101, 0);
    chk("scalar_latency", (log_c.size() > 0) ? log_c[0] - a : -1, 1);

    // Vector op=101 len=3
    clear_log();
    send(1'b0, 3'b101, 4'd3, a);
    wait_idle();
    chk("vec3_count", log_e.size(), 3);
    chk_beat("vec3_b0", 0, 5'b01010, 0);
    chk_beat("vec3_b1", 1, 5'b01010, 1);
    chk_beat("vec3_b2", 2, 5'b01011, 2);
    chk("vec3_consecutive", (log_c.size() == 3) ? log_c[2] - log_c[0] : -1, 2);

    // Stall mid-burst on op=100 len=2
    clear_log();
    send(1'b0, 3'b100, 4'd2, a);
    @(posedge clk); #1 exec_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1 exec_ready = 1'b1;
    wait_idle();
    chk("stall_count", log_e.size(), 2);
    chk_beat("stall_b0", 0, 5'b01000, 0);
    chk_beat("stall_b1", 1, 5'b01001, 1);

    // Back-to-back: vector len=1 then special
    clear_log();
    send(1'b0, 3'b001, 4'd1, a);
    send(1'b1, 3'b000, 4'd0, b);
    wait_idle();
    chk("b2b_count", log_e.size(), 2);
    chk_beat("b2b_b0", 0, 5'b00011, 0);
    chk_beat("b2b_b1", 1, 5'b11111, 0);
    chk("b2b_no_bubble", (log_c.size() == 2) ? log_c[1] - log_c[0] : -1, 1);

    // len=0 means MAX_LEN
    clear_log();
    send(1'b0, 3'b110, 4'd0, a);
    wait_idle();
    chk("len0_count", log_e.size(), 16);
    chk_beat("len0_last", 15, 5'b01101, 15);
    nlast = 0;
    foreach (log_e[k]) nlast += log_e[k] & 1;
    chk("len0_last_flags", nlast, 1);

    // Reset in the middle of a len=8 vector
    clear_log();
    send(1'b0, 3'b110, 4'd8, a);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (exec_valid && elem_idx == 4'd2) begin seen = 1; break; end
    end
    chk("reach_idx2", int'(seen), 1);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_exec_valid", int'(exec_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_elem_idx", int'(elem_idx), 0);
    chk("midrst_count", log_e.size(), 2);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    // func=0 op=111
    clear_log();
    send(1'b0, 3'b111, 4'd0, a);
    wait_idle();
`ifdef EXEC_ENCODER_ILLEGAL_DROP_EN
    chk("illegal_count", log_e.size(), 0);
`else
    chk("illegal_count", log_e.size(), 1);
    chk_beat("illegal", 0, 5'b01111, 0);
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
